// File: rtl/wb_stage_if.sv
// Handshake and register-file bundle between the MEM stage and the write-back stage.
// The MEM side uses the master modport and the write-back stage uses the slave modport.
interface wb_stage_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  mem_valid_i;
    logic                  mem_ready_o;
    logic                  flush_i;
    logic [REG_ADDR_W-1:0] rd_i;
    logic                  wb_reg_wr_i;
    logic                  wb_mem_sel_i;
    logic [2:0]            ld_funct3_i;
    logic [1:0]            ld_off_i;
    logic [31:0]           alu_i;
    logic [31:0]           d_mem_i;
    logic                  d_mem_valid_i;
    logic                  rf_we_o;
    logic [REG_ADDR_W-1:0] rf_rd_o;
    logic [31:0]           rf_data_o;
    logic                  misalign_o;
    logic                  ld_timeout_o;
    logic                  retire_o;

    modport master (
        output mem_valid_i, flush_i, rd_i, wb_reg_wr_i, wb_mem_sel_i,
               ld_funct3_i, ld_off_i, alu_i, d_mem_i, d_mem_valid_i,
        input  mem_ready_o, rf_we_o, rf_rd_o, rf_data_o, misalign_o,
               ld_timeout_o, retire_o
    );

    modport slave (
        input  mem_valid_i, flush_i, rd_i, wb_reg_wr_i, wb_mem_sel_i,
               ld_funct3_i, ld_off_i, alu_i, d_mem_i, d_mem_valid_i,
        output mem_ready_o, rf_we_o, rf_rd_o, rf_data_o, misalign_o,
               ld_timeout_o, retire_o
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// RV32I write-back stage: waits for load data, extracts/extends it, drives the RF write port.
// Optional retire counter (instret_o) is built when WB_RETIRE_CNT_EN is defined.
//
// state     | meaning
// S_IDLE    | ready for a new instruction; completes non-loads and same-cycle loads
// S_WAIT_LD | holding an accepted load until data arrives, a flush, or the timeout
module wb_stage_pipe #(
    parameter int REG_ADDR_W = 5,
    parameter int LD_TIMEOUT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    wb_stage_if.slave        wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] instret_o
`endif
);
    typedef enum logic [0:0] {S_IDLE, S_WAIT_LD} state_t;

    localparam logic [7:0] TO_LIM = 8'(LD_TIMEOUT);

    state_t                state_q;
    logic [7:0]            cnt_q;
    logic [REG_ADDR_W-1:0] ld_rd_q;
    logic                  ld_wr_q;
    logic [2:0]            ld_f3_q;
    logic [1:0]            ld_off_q;

    logic                  ready_q;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_rd_q;
    logic [31:0]           rf_data_q;
    logic                  misalign_q;
    logic                  timeout_q;
    logic                  retire_q;

    logic                  in_wait;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic                  sel_wr;
    logic                  sel_load;
    logic [2:0]            sel_f3;
    logic [1:0]            sel_off;
    logic [31:0]           res_data;
    logic                  res_mis;
    logic                  res_we;
    logic                  accept;
    logic                  done;

    function automatic logic [31:0] ld_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  ld_extract = {{24{b[7]}}, b};
            3'b100:  ld_extract = {24'd0, b};
            3'b001:  ld_extract = {{16{h[15]}}, h};
            3'b101:  ld_extract = {16'd0, h};
            default: ld_extract = w;
        endcase
    endfunction

    // Completion source is the latched load while waiting, otherwise the live MEM inputs.
    always_comb begin
        in_wait  = (state_q == S_WAIT_LD);
        sel_rd   = in_wait ? ld_rd_q  : wb.rd_i;
        sel_wr   = in_wait ? ld_wr_q  : wb.wb_reg_wr_i;
        sel_f3   = in_wait ? ld_f3_q  : wb.ld_funct3_i;
        sel_off  = in_wait ? ld_off_q : wb.ld_off_i;
        sel_load = in_wait | wb.wb_mem_sel_i;
        res_mis  = sel_load & ((((sel_f3 == 3'b001) | (sel_f3 == 3'b101)) & sel_off[0]) |
                               ((sel_f3 == 3'b010) & (sel_off != 2'b00)));
        res_data = sel_load ? ld_extract(sel_f3, sel_off, wb.d_mem_i) : wb.alu_i;
        res_we   = sel_wr & (sel_rd != '0) & ~res_mis;
        accept   = ~in_wait & wb.mem_valid_i & ~wb.flush_i;
        done     = (accept & (~wb.wb_mem_sel_i | wb.d_mem_valid_i)) |
                   (in_wait & ~wb.flush_i & wb.d_mem_valid_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            ld_rd_q    <= '0;
            ld_wr_q    <= 1'b0;
            ld_f3_q    <= 3'b000;
            ld_off_q   <= 2'b00;
            ready_q    <= 1'b1;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= 32'd0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            retire_q   <= 1'b0;
        end else begin
            rf_we_q    <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
            retire_q   <= 1'b0;
            if (done) begin
                rf_we_q    <= res_we;
                rf_rd_q    <= sel_rd;
                rf_data_q  <= res_data;
                misalign_q <= res_mis;
                retire_q   <= ~res_mis;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept && wb.wb_mem_sel_i && !wb.d_mem_valid_i) begin
                        state_q  <= S_WAIT_LD;
                        ready_q  <= 1'b0;
                        cnt_q    <= 8'd0;
                        ld_rd_q  <= wb.rd_i;
                        ld_wr_q  <= wb.wb_reg_wr_i;
                        ld_f3_q  <= wb.ld_funct3_i;
                        ld_off_q <= wb.ld_off_i;
                    end
                end
                S_WAIT_LD: begin
                    if (wb.flush_i || wb.d_mem_valid_i) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end else if (cnt_q + 8'd1 == TO_LIM) begin
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign wb.mem_ready_o  = ready_q;
    assign wb.rf_we_o      = rf_we_q;
    assign wb.rf_rd_o      = rf_rd_q;
    assign wb.rf_data_o    = rf_data_q;
    assign wb.misalign_o   = misalign_q;
    assign wb.ld_timeout_o = timeout_q;
    assign wb.retire_o     = retire_q;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (done && !res_mis) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret_o = instret_q;
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Randomized self-checking bench for wb_stage_pipe against a transaction-level model.
// Checks instret_o as well when built with WB_RETIRE_CNT_EN.
module tb_wb_stage_pipe;
    localparam int LDT   = 15;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [CNT_W-1:0] exp_instret = '0;

    always #5 clk = ~clk;

    wb_stage_if #(.REG_ADDR_W(5)) bus ();

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] instret;
    wb_stage_pipe #(.REG_ADDR_W(5), .LD_TIMEOUT(LDT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .wb(bus.slave), .instret_o(instret));
`else
    wb_stage_pipe #(.REG_ADDR_W(5), .LD_TIMEOUT(LDT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .wb(bus.slave));
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input logic we, input logic [4:0] rd, input logic [31:0] data,
                             input logic mis, input logic to, input logic ret, input logic rdy);
        chk("rf_we", 32'(bus.rf_we_o), 32'(we));
        if (we) begin
            chk("rf_rd", 32'(bus.rf_rd_o), 32'(rd));
            chk("rf_data", bus.rf_data_o, data);
        end
        chk("misalign", 32'(bus.misalign_o), 32'(mis));
        chk("ld_timeout", 32'(bus.ld_timeout_o), 32'(to));
        chk("retire", 32'(bus.retire_o), 32'(ret));
        chk("mem_ready", 32'(bus.mem_ready_o), 32'(rdy));
`ifdef WB_RETIRE_CNT_EN
        chk("instret", 32'(instret), 32'(exp_instret));
`endif
    endtask

    task automatic set_idle();
        bus.mem_valid_i   = 1'b0;
        bus.flush_i       = 1'b0;
        bus.d_mem_valid_i = 1'b0;
        bus.rd_i          = 5'($urandom);
        bus.wb_reg_wr_i   = 1'($urandom);
        bus.wb_mem_sel_i  = 1'($urandom);
        bus.ld_funct3_i   = 3'($urandom);
        bus.ld_off_i      = 2'($urandom);
        bus.alu_i         = $urandom;
        bus.d_mem_i       = $urandom;
    endtask

    // Architectural result of one retiring instruction.
    task automatic expect_result(input logic [4:0] rd, input logic wr, input logic sel,
                                 input logic [2:0] f3, input logic [1:0] off,
                                 input logic [31:0] alu, input logic [31:0] dmem);
        logic [31:0] data;
        logic        mis;
        int unsigned bval, hval;
        mis  = 1'b0;
        data = alu;
        if (sel) begin
            bval = (dmem >> (8 * int'(off))) % 256;
            hval = (dmem >> (16 * (int'(off) / 2))) % 65536;
            case (int'(f3))
                0:       data = (bval >= 128) ? bval + 32'hFFFF_FF00 : bval;
                4:       data = bval;
                1:       data = (hval >= 32768) ? hval + 32'hFFFF_0000 : hval;
                5:       data = hval;
                default: data = dmem;
            endcase
            mis = ((f3 == 3'd1 || f3 == 3'd5) && (int'(off) % 2 == 1)) ||
                  (f3 == 3'd2 && off != 2'd0);
        end
        if (!mis) exp_instret = exp_instret + 1'b1;
        check_out(wr && rd != 5'd0 && !mis, rd, data, mis, 1'b0, !mis, 1'b1);
    endtask

    // delay: cycles after accept until load data (0 = same cycle, > LDT = never).
    // flush_at: WAIT_LD cycle carrying flush_i (0 = none).
    task automatic run_txn(input logic [4:0] rd, input logic wr, input logic sel,
                           input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] alu, input logic [31:0] dmem,
                           input int delay, input int flush_at);
        bus.mem_valid_i   = 1'b1;
        bus.flush_i       = 1'b0;
        bus.rd_i          = rd;
        bus.wb_reg_wr_i   = wr;
        bus.wb_mem_sel_i  = sel;
        bus.ld_funct3_i   = f3;
        bus.ld_off_i      = off;
        bus.alu_i         = alu;
        bus.d_mem_i       = (sel && delay == 0) ? dmem : $urandom;
        bus.d_mem_valid_i = sel ? (delay == 0) : 1'($urandom);
        tick();
        if (!sel || delay == 0) begin
            expect_result(rd, wr, sel, f3, off, alu, dmem);
        end else begin
            check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int i = 1; i <= LDT; i++) begin
                set_idle();
                bus.mem_valid_i   = 1'($urandom);
                bus.flush_i       = (i == flush_at);
                bus.d_mem_valid_i = (i == delay);
                if (i == delay) bus.d_mem_i = dmem;
                tick();
                if (i == flush_at) begin
                    check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
                    break;
                end else if (i == delay) begin
                    expect_result(rd, wr, sel, f3, off, alu, dmem);
                    break;
                end else if (i == LDT) begin
                    check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
                    break;
                end else begin
                    check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        repeat (3) @(negedge clk);
        check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_rf_rd", 32'(bus.rf_rd_o), 32'd0);
        chk("rst_rf_data", bus.rf_data_o, 32'd0);
        rst = 1'b0;
        tick();
        check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        run_txn(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_1234, 32'd0, 0, 0);
        run_txn(5'd7, 1'b1, 1'b1, 3'b000, 2'd3, 32'd0, 32'h80FF_0000, 0, 0);
        run_txn(5'd7, 1'b1, 1'b1, 3'b100, 2'd3, 32'd0, 32'h80FF_0000, 0, 0);
        run_txn(5'd8, 1'b1, 1'b1, 3'b001, 2'd1, 32'd0, 32'h1234_5678, 0, 0);
        run_txn(5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0, 32'hCAFE_F00D, 4, 0);
        run_txn(5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0, 32'hCAFE_F00D, 99, 0);
        run_txn(5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0, 32'hCAFE_F00D, 99, 3);
        run_txn(5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0, 32'h1111_2222, LDT, 0);
        for (int i = 0; i < 3; i++)
            run_txn(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, $urandom, 32'd0, 0, 0);

        // Accept blocked by flush in IDLE.
        bus.mem_valid_i = 1'b1;
        bus.flush_i     = 1'b1;
        bus.rd_i        = 5'd3;
        tick();
        check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_idle();

        // Reset while a load is waiting drops it.
        bus.mem_valid_i  = 1'b1;
        bus.wb_mem_sel_i = 1'b1;
        bus.wb_reg_wr_i  = 1'b1;
        bus.rd_i         = 5'd4;
        tick();
        check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_idle();
        rst = 1'b1;
        #1;
        exp_instret = '0;
        check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        bus.d_mem_valid_i = 1'b1;
        tick();
        check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_idle();

        for (int n = 0; n < 300; n++) begin
            int dly, fl;
            dly = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, LDT + 2));
            fl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LDT)) : 0;
            run_txn(5'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom),
                    $urandom, $urandom, dly, fl);
            if ($urandom_range(0, 3) == 0) begin
                bus.mem_valid_i   = 1'($urandom);
                bus.flush_i       = 1'b1;
                bus.d_mem_valid_i = 1'($urandom);
                tick();
                check_out(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
                set_idle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
